prog_loader: RTL and testbench

Boot-time program loader. It is the write-side counterpart to the instruction fetch path: it takes a framed little-endian byte stream (length, payload, checksum) and writes 32-bit words into `memory` through the data write port (`dwe`/`daddr`/`ddatain`). It holds the core in reset until a checksum-verified image is resident. It sits between the host byte link (UART RX or bench driver) and `memory`, and drives the core's `rst`.

---
 rtl/prog_loader.sv | 129 ++++++++++++
 tb/tb_prog_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: framed byte stream to memory write port.
// Holds the core in reset until a checksum-verified image is resident.
module prog_loader #(
  parameter int MEM_WIDTH = 16,
  parameter int BASE      = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [31:0] ddatain,
  output logic        core_rst,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  logic [1:0]  r_bc;
  logic [23:0] r_shift;
  logic [31:0] r_len;
  logic [31:0] r_idx;
  logic [31:0] r_sum;
  logic        r_dwe;
  logic [31:0] r_daddr;
  logic [31:0] r_ddatain;
  logic        r_core_rst;
  logic        r_done;
  logic        r_err;

  logic        w_active;
  logic        w_fire;
  logic        w_last;
  logic [31:0] w_word;
  logic [31:0] w_sum;
  logic [31:0] w_idx1;
  logic [32:0] w_cap;

  assign w_active = (r_state == S_LEN) ||
                    (r_state == S_DATA) ||
                    (r_state == S_CSUM);
  assign in_ready = !rst && w_active;
  assign w_fire   = in_valid && in_ready;
  assign w_last   = (r_bc == 2'd3);
  // Bytes enter at the top and shift down: first byte ends in [7:0].
  assign w_word   = {in_data, r_shift};
  assign w_sum    = r_sum + w_word;
  assign w_idx1   = r_idx + 32'd1;
  assign w_cap    = 33'd1 << MEM_WIDTH;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_LEN;
      r_bc       <= 2'd0;
      r_shift    <= 24'd0;
      r_len      <= 32'd0;
      r_idx      <= 32'd0;
      r_sum      <= 32'd0;
      r_dwe      <= 1'b0;
      r_daddr    <= 32'd0;
      r_ddatain  <= 32'd0;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_dwe <= 1'b0;
      if (w_fire) begin
        r_bc    <= r_bc + 2'd1;
        r_shift <= w_word[31:8];
        unique case (r_state)
          S_LEN: begin
            if (w_last) begin
              r_len <= w_word;
              if ({1'b0, w_word} > w_cap) begin
                r_state <= S_ERR;
                r_err   <= 1'b1;
              end else if (w_word == 32'd0) begin
                r_state <= S_CSUM;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (w_last) begin
              r_dwe     <= 1'b1;
              r_daddr   <= 32'(BASE) + r_idx;
              r_ddatain <= w_word;
              r_sum     <= w_sum;
              r_idx     <= w_idx1;
              if (w_idx1 == r_len) r_state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (w_last) begin
              if (w_word == r_sum) begin
                r_state    <= S_DONE;
                r_done     <= 1'b1;
                r_core_rst <= 1'b0;
              end else begin
                r_state <= S_ERR;
                r_err   <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dwe      = r_dwe;
  assign daddr    = r_daddr;
  assign ddatain  = r_ddatain;
  assign core_rst = r_core_rst;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed frame-level bench for prog_loader.
// Writes are captured on the falling edge and compared per frame.
module tb_prog_loader;

  localparam int MW   = 4;
  localparam int BASE = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        dwe;
  logic [31:0] daddr;
  logic [31:0] ddatain;
  logic        core_rst;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  prog_loader #(.MEM_WIDTH(MW), .BASE(BASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .dwe      (dwe),
    .daddr    (daddr),
    .ddatain  (ddatain),
    .core_rst (core_rst),
    .done     (done),
    .err      (err)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  logic [63:0] wq[$];
  int          wc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (dwe === 1'b1) begin
      wq.push_back({daddr, ddatain});
      wc.push_back(cyc);
    end

  typedef struct {
    logic [31:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] csum;
    bit          gaps;
    bit          exp_done;
    bit          exp_err;
    int          exp_nw;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (in_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_vec++;
      n_miss++;
      $display("FAIL accept: byte %h not taken within 20 cycles", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_dwe", {31'd0, dwe}, 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    chk("rst_ddatain", ddatain, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    wq.delete();
    wc.delete();
  endtask

  task automatic chk_end(input bit e_done, input bit e_err);
    chk("done", {31'd0, done}, {31'd0, e_done});
    chk("err", {31'd0, err}, {31'd0, e_err});
    chk("core_rst", {31'd0, core_rst}, {31'd0, !e_done});
    chk("in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    // len, w0, w1, csum, gaps, done, err, writes
    tbl[0] = '{32'd2, 32'h00000013, 32'hDEADBEEF, 32'hDEADBF02, 0, 1, 0, 2};
    tbl[1] = '{32'd2, 32'h00000013, 32'hDEADBEEF, 32'hDEADBF03, 0, 0, 1, 2};
    tbl[2] = '{32'd0, 32'h0, 32'h0, 32'h00000000, 0, 1, 0, 0};
    tbl[3] = '{32'd0, 32'h0, 32'h0, 32'h00000001, 0, 0, 1, 0};
    tbl[4] = '{32'd17, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0};
    tbl[5] = '{32'd1, 32'h01020304, 32'h0, 32'h01020304, 1, 1, 0, 1};
    tbl[6] = '{32'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 0, 1, 0, 2};
    tbl[7] = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      send_word(tbl[v].len, tbl[v].gaps);
      if (tbl[v].len <= 32'd16) begin
        for (int i = 0; i < int'(tbl[v].len); i++)
          send_word(i == 0 ? tbl[v].w0 : tbl[v].w1, tbl[v].gaps);
        send_word(tbl[v].csum, tbl[v].gaps);
      end
      in_valid = 1'b0;
      #1;
      chk_end(tbl[v].exp_done, tbl[v].exp_err);
      if (tbl[v].len > 32'd16) begin
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("ovf_in_ready", {31'd0, in_ready}, 32'd0);
        chk("ovf_err_hold", {31'd0, err}, 32'd1);
      end
      chk("nwrites", wq.size(), tbl[v].exp_nw);
      for (int i = 0; i < tbl[v].exp_nw && i < wq.size(); i++) begin
        chk("waddr", wq[i][63:32], 32'(BASE + i));
        chk("wdata", wq[i][31:0], i == 0 ? tbl[v].w0 : tbl[v].w1);
        if (i > 0 && !tbl[v].gaps)
          chk("wspacing", wc[i] - wc[i-1], 32'd4);
      end
    end

    // Reset mid-load, then a fresh length-1 frame.
    do_reset();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    do_reset();
    chk("mid_nwrites0", wq.size(), 32'd0);
    send_word(32'd1, 0);
    send_word(32'hCAFEF00D, 0);
    send_word(32'hCAFEF00D, 0);
    in_valid = 1'b0;
    #1;
    chk_end(1'b1, 1'b0);
    chk("mid_nwrites", wq.size(), 32'd1);
    if (wq.size() > 0) begin
      chk("mid_waddr", wq[0][63:32], 32'(BASE));
      chk("mid_wdata", wq[0][31:0], 32'hCAFEF00D);
    end

    // Largest legal image: exactly 2^MW words, word i = i, sum 120.
    do_reset();
    send_word(32'd16, 0);
    for (int i = 0; i < 16; i++) send_word(32'(i), 0);
    send_word(32'd120, 0);
    in_valid = 1'b0;
    #1;
    chk_end(1'b1, 1'b0);
    chk("full_nwrites", wq.size(), 32'd16);
    if (wq.size() == 16) begin
      chk("full_last_addr", wq[15][63:32], 32'(BASE + 15));
      chk("full_last_data", wq[15][31:0], 32'd15);
    end
    @(negedge clk);
    chk("done_sticky", {31'd0, done}, 32'd1);
    chk("dwe_low", {31'd0, dwe}, 32'd0);
    chk("daddr_hold", daddr, 32'(BASE + 15));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
